display_input: RTL and testbench

- Board-side input block that assembles one N-bit data word from two N/2-bit halves entered on the slide switches.
- Each half is committed by pressing an "enter" push-button: the upper half first, then the lower half.
- It is the input-side counterpart of the time-multiplexed half-word display path. It sits between the board switches/button and the processor's input port, and hands words over with a valid/ack handshake.
- The button is synchronised and debounced internally.

---
 rtl/display_io_pkg.sv | 14 +
 rtl/button_debounce.sv | 58 +++++
 rtl/display_input.sv | 88 ++++++++
 tb/tb_display_input.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/display_io_pkg.sv
// Shared types and defaults for the board-side input path: FSM state
// encoding for word assembly and the default button debounce interval.
package display_io_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_HI = 2'd1,
    WAIT_LO = 2'd2,
    VALID   = 2'd3
  } state_e;

  localparam int unsigned DEFAULT_DEBOUNCE = 250000;

endpackage

// File: rtl/button_debounce.sv
// Synchronises and debounces one raw push-button and emits a single-cycle
// pulse on each accepted press; releases are filtered but never pulse.
module button_debounce
  import display_io_pkg::*;
#(
  parameter int unsigned DEBOUNCE = DEFAULT_DEBOUNCE
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_level,
  output logic press
);

  localparam int unsigned CW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] CntLast = CW'(DEBOUNCE - 1);

  logic          sync0_q, sync1_q;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The level flips only after DEBOUNCE consecutive differing samples;
  // any agreeing sample restarts the count.
  always_comb begin
    level_d = level_q;
    press_d = 1'b0;
    cnt_d   = '0;
    if (sync1_q != level_q) begin
      if (cnt_q == CntLast) begin
        level_d = ~level_q;
        press_d = ~level_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync0_q <= 1'b0;
      sync1_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync0_q <= btn_raw;
      sync1_q <= sync0_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign btn_level = level_q;
  assign press     = press_q;

endmodule

// File: rtl/display_input.sv
// Assembles an N-bit word from two switch halves committed by the enter
// button (upper first) and hands it to the consumer via valid/ack.
module display_input
  import display_io_pkg::*;
#(
  parameter int unsigned N        = 32,
  parameter int unsigned DEBOUNCE = DEFAULT_DEBOUNCE
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N/2-1:0] sw_data,
  input  logic           enter,
  input  logic           req,
  input  logic           ack,
  output logic [N-1:0]   word_data,
  output logic           word_valid,
  output logic           half_sel,
  output logic           busy
);

  localparam int unsigned H = N / 2;

  state_e       state_q, state_d;
  logic [N-1:0] word_q, word_d;
  logic         valid_q, half_q, busy_q;
  logic         btnLevel, btnPress, commit;

  button_debounce #(.DEBOUNCE(DEBOUNCE)) u_debounce (
    .clk      (clk),
    .rst      (rst),
    .btn_raw  (enter),
    .btn_level(btnLevel),
    .press    (btnPress)
  );

  // A press pulse always coincides with the accepted level being high.
  assign commit = btnPress & btnLevel;

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    case (state_q)
      IDLE: begin
        if (req) state_d = WAIT_HI;
      end
      WAIT_HI: begin
        if (commit) begin
          word_d[N-1:H] = sw_data;
          state_d       = WAIT_LO;
        end
      end
      WAIT_LO: begin
        if (commit) begin
          word_d[H-1:0] = sw_data;
          state_d       = VALID;
        end
      end
      VALID: begin
        if (ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Status outputs are decoded from the next state so they register
  // alongside the state itself.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      word_q  <= '0;
      valid_q <= 1'b0;
      half_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      valid_q <= (state_d == VALID);
      half_q  <= (state_d == WAIT_HI);
      busy_q  <= (state_d == WAIT_HI) || (state_d == WAIT_LO);
    end
  end

  assign word_data  = word_q;
  assign word_valid = valid_q;
  assign half_sel   = half_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_display_input.sv
// Self-checking bench for display_input: directed scenarios plus a random
// phase, all compared against a behavioural model of the entry protocol.
module tb_display_input;

  localparam int N = 32;
  localparam int H = 16;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         enter;
  logic         req;
  logic         ack;
  logic [H-1:0] sw;
  logic [N-1:0] word_data;
  logic         word_valid;
  logic         half_sel;
  logic         busy;

  int vecCount  = 0;
  int missCount = 0;

  always #5 clk = ~clk;

  display_input #(.N(N), .DEBOUNCE(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .sw_data   (sw),
    .enter     (enter),
    .req       (req),
    .ack       (ack),
    .word_data (word_data),
    .word_valid(word_valid),
    .half_sel  (half_sel),
    .busy      (busy)
  );

  // Model: button accepted after D consecutive synchronised samples at the
  // new level; protocol tracked as a phase of word entry.
  typedef enum int {P_IDLE, P_HI, P_LO, P_DONE} phase_t;

  logic         rawHist[$];
  logic         recent[$];
  logic         mLevel;
  logic         mPressSeen;
  phase_t       mPhase;
  logic [N-1:0] mWord;

  function automatic void modelReset();
    rawHist.delete();
    recent.delete();
    mLevel     = 1'b0;
    mPressSeen = 1'b0;
    mPhase     = P_IDLE;
    mWord      = '0;
  endfunction

  function automatic void modelEdge();
    logic syncBit;
    logic pressNow;
    bit   allDiff;
    if (!rst) begin
      modelReset();
      return;
    end
    case (mPhase)
      P_IDLE: if (req) mPhase = P_HI;
      P_HI: if (mPressSeen) begin
        mWord[N-1:H] = sw;
        mPhase = P_LO;
      end
      P_LO: if (mPressSeen) begin
        mWord[H-1:0] = sw;
        mPhase = P_DONE;
      end
      P_DONE: if (ack) mPhase = P_IDLE;
      default: mPhase = P_IDLE;
    endcase
    rawHist.push_back(enter);
    syncBit = (rawHist.size() >= 3) ? rawHist[rawHist.size()-3] : 1'b0;
    if (rawHist.size() > 3) void'(rawHist.pop_front());
    recent.push_back(syncBit);
    if (recent.size() > D) void'(recent.pop_front());
    pressNow = 1'b0;
    allDiff  = (recent.size() == D);
    foreach (recent[i]) if (recent[i] == mLevel) allDiff = 0;
    if (allDiff) begin
      pressNow = !mLevel;
      mLevel   = !mLevel;
      recent.delete();
    end
    mPressSeen = pressNow;
  endfunction

  task automatic checkOutput(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    vecCount++;
    assert (obs === exp) else begin
      missCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: model advances on the edge, outputs compared on the falling edge.
  task automatic applyStimulus();
    @(posedge clk);
    modelEdge();
    @(negedge clk);
    checkOutput("word_data", word_data, mWord);
    checkOutput("word_valid", 32'(word_valid), 32'(mPhase == P_DONE));
    checkOutput("half_sel", 32'(half_sel), 32'(mPhase == P_HI));
    checkOutput("busy", 32'(busy), 32'(mPhase == P_HI || mPhase == P_LO));
  endtask

  task automatic pressHalf(input logic [H-1:0] v);
    sw    = v;
    enter = 1'b1;
    repeat (10) applyStimulus();
    enter = 1'b0;
    repeat (10) applyStimulus();
  endtask

  initial begin
    logic [H-1:0] hiVal, loVal;
    int           segLeft;

    rst   = 1'b0;
    enter = 1'b1;
    req   = 1'b1;
    ack   = 1'b0;
    sw    = '0;
    modelReset();

    // Reset held with enter and req active
    repeat (3) applyStimulus();
    checkOutput("rst_word", word_data, 32'd0);
    checkOutput("rst_valid", 32'(word_valid), 32'd0);
    checkOutput("rst_half", 32'(half_sel), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    enter = 1'b0;
    rst   = 1'b1;
    applyStimulus();
    checkOutput("rst_exit_hi", 32'(half_sel), 32'd1);

    // Normal word with exact press latency
    sw    = 16'hDEAD;
    enter = 1'b1;
    repeat (6) applyStimulus();
    checkOutput("hi_before_commit", 32'(half_sel), 32'd1);
    applyStimulus();
    checkOutput("hi_after_commit", 32'(half_sel), 32'd0);
    checkOutput("busy_in_lo", 32'(busy), 32'd1);
    repeat (3) applyStimulus();
    enter = 1'b0;
    repeat (10) applyStimulus();
    sw    = 16'hBEEF;
    enter = 1'b1;
    repeat (6) applyStimulus();
    checkOutput("valid_before", 32'(word_valid), 32'd0);
    applyStimulus();
    checkOutput("valid_after", 32'(word_valid), 32'd1);
    checkOutput("word1", word_data, 32'hDEADBEEF);
    repeat (3) applyStimulus();
    enter = 1'b0;
    repeat (10) applyStimulus();

    // Handshake hold: no ack, switches change, a press arrives
    for (int i = 0; i < 50; i++) begin
      sw = 16'($urandom);
      if (i == 10) enter = 1'b1;
      if (i == 25) enter = 1'b0;
      applyStimulus();
    end
    checkOutput("hold_word", word_data, 32'hDEADBEEF);
    checkOutput("hold_valid", 32'(word_valid), 32'd1);

    // Back-to-back: req stays high across ack
    ack = 1'b1;
    applyStimulus();
    ack = 1'b0;
    checkOutput("ack_valid_drop", 32'(word_valid), 32'd0);
    checkOutput("ack_idle_busy", 32'(busy), 32'd0);
    checkOutput("ack_idle_half", 32'(half_sel), 32'd0);
    applyStimulus();
    checkOutput("b2b_hi", 32'(half_sel), 32'd1);
    pressHalf(16'h1234);
    pressHalf(16'h5678);
    checkOutput("word2", word_data, 32'h12345678);
    checkOutput("word2_valid", 32'(word_valid), 32'd1);
    ack = 1'b1;
    req = 1'b0;
    applyStimulus();
    ack = 1'b0;
    applyStimulus();

    // Bounce rejection
    req = 1'b1;
    applyStimulus();
    req   = 1'b0;
    hiVal = 16'($urandom);
    sw    = hiVal;
    for (int i = 0; i < 20; i++) begin
      enter = ((i / 2) % 2) == 1;
      applyStimulus();
    end
    checkOutput("bounce_no_press", 32'(half_sel), 32'd1);
    enter = 1'b1;
    repeat (12) applyStimulus();
    checkOutput("bounce_in_lo", 32'(busy & ~half_sel), 32'd1);
    checkOutput("bounce_upper", 32'(word_data[N-1:H]), 32'(hiVal));
    enter = 1'b0;
    repeat (10) applyStimulus();
    checkOutput("bounce_single", 32'(word_valid), 32'd0);
    loVal = 16'($urandom);
    pressHalf(loVal);
    checkOutput("bounce_word", word_data, {hiVal, loVal});
    ack = 1'b1;
    applyStimulus();
    ack = 1'b0;
    applyStimulus();

    // Reset in the middle of entry
    req = 1'b1;
    applyStimulus();
    pressHalf(16'hCAFE);
    checkOutput("cafe_upper", 32'(word_data[N-1:H]), 32'h0000CAFE);
    rst = 1'b0;
    #1;
    checkOutput("rst_async_word", word_data, 32'd0);
    checkOutput("rst_async_busy", 32'(busy), 32'd0);
    modelReset();
    repeat (2) applyStimulus();
    rst = 1'b1;
    hiVal = 16'($urandom);
    loVal = 16'($urandom);
    applyStimulus();
    pressHalf(hiVal);
    pressHalf(loVal);
    checkOutput("fresh_word", word_data, {hiVal, loVal});
    checkOutput("fresh_valid", 32'(word_valid), 32'd1);

    // Random traffic on every input
    segLeft = 0;
    for (int i = 0; i < 3000; i++) begin
      if (segLeft == 0) begin
        enter   = ~enter;
        segLeft = $urandom_range(1, 9);
      end
      segLeft--;
      sw  = 16'($urandom);
      req = $urandom_range(0, 3) != 0;
      ack = $urandom_range(0, 3) == 0;
      applyStimulus();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
